// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-paced falling-text / ring-texture scene sequencer
// Config writes are staged mid-frame and committed on the frame_strobe edge.
module scene_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  output logic        cfg_ready,
  output logic        frame_strobe,
  output logic [15:0] frame_cnt,
  output logic [9:0]  text_y,
  output logic        text_en,
  output logic [7:0]  ring_phase,
  output logic [1:0]  scene_state
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_FALL    = 2'd1,
    ST_SWALLOW = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  localparam logic [9:0] TOP_Y    = 10'd20;
  localparam logic [9:0] BOTTOM_Y = 10'd208;

  state_t      state;
  logic        vsync_q;
  logic [7:0]  stg_wait, stg_step, stg_speed;
  logic [1:0]  stg_ctrl;
  logic [7:0]  act_wait, act_step, act_speed;
  logic [1:0]  act_ctrl;
  logic [7:0]  wait_cnt;
  logic [4:0]  swallow_cnt;
  logic        run_rise;
  logic [7:0]  step_eff;
  logic [9:0]  fall_sum;
  logic        act_run, act_loop;

  assign cfg_ready   = ~frame_strobe;
  assign scene_state = state;
  assign act_run     = act_ctrl[0];
  assign act_loop    = act_ctrl[1];

  always_comb begin
    step_eff = (act_step == 8'd0) ? 8'd1 : act_step;
    fall_sum = text_y + {2'b00, step_eff};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_WAIT;
      vsync_q      <= 1'b1;
      frame_strobe <= 1'b0;
      frame_cnt    <= 16'd0;
      text_y       <= TOP_Y;
      text_en      <= 1'b1;
      ring_phase   <= 8'd0;
      wait_cnt     <= 8'd0;
      swallow_cnt  <= 5'd0;
      run_rise     <= 1'b0;
      stg_wait     <= 8'd60;
      stg_step     <= 8'd1;
      stg_speed    <= 8'd1;
      stg_ctrl     <= 2'b11;
      act_wait     <= 8'd60;
      act_step     <= 8'd1;
      act_speed    <= 8'd1;
      act_ctrl     <= 2'b11;
    end else begin
      vsync_q      <= vsync;
      frame_strobe <= vsync & ~vsync_q;

      if (cfg_valid && cfg_ready) begin
        case (cfg_addr)
          2'd0:    stg_wait  <= cfg_data;
          2'd1:    stg_step  <= cfg_data;
          2'd2:    stg_speed <= cfg_data;
          default: stg_ctrl  <= cfg_data[1:0];
        endcase
      end

      // Scene update uses the pre-commit active config; staging lands in the same edge.
      if (frame_strobe) begin
        frame_cnt <= frame_cnt + 16'd1;
        act_wait  <= stg_wait;
        act_step  <= stg_step;
        act_speed <= stg_speed;
        act_ctrl  <= stg_ctrl;
        run_rise  <= stg_ctrl[0] & ~act_ctrl[0];

        case (state)
          ST_WAIT: begin
            ring_phase <= ring_phase + act_speed;
            if (!act_run) begin
              state   <= ST_HALT;
              text_y  <= TOP_Y;
              text_en <= 1'b0;
            end else if (wait_cnt == act_wait) begin
              state <= ST_FALL;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          ST_FALL: begin
            ring_phase <= ring_phase + act_speed;
            if (!act_run) begin
              state   <= ST_HALT;
              text_y  <= TOP_Y;
              text_en <= 1'b0;
            end else if (fall_sum >= BOTTOM_Y) begin
              state       <= ST_SWALLOW;
              text_y      <= BOTTOM_Y;
              text_en     <= 1'b0;
              swallow_cnt <= 5'd0;
            end else begin
              text_y <= fall_sum;
            end
          end
          ST_SWALLOW: begin
            ring_phase <= ring_phase + {act_speed[6:0], 1'b0};
            if (!act_run || (swallow_cnt == 5'd31 && !act_loop)) begin
              state   <= ST_HALT;
              text_y  <= TOP_Y;
              text_en <= 1'b0;
            end else if (swallow_cnt == 5'd31) begin
              state    <= ST_WAIT;
              text_y   <= TOP_Y;
              text_en  <= 1'b1;
              wait_cnt <= 8'd0;
            end else begin
              swallow_cnt <= swallow_cnt + 5'd1;
            end
          end
          default: begin
            if (act_run && (act_loop || run_rise)) begin
              state    <= ST_WAIT;
              text_y   <= TOP_Y;
              text_en  <= 1'b1;
              wait_cnt <= 8'd0;
            end
          end
        endcase
      end
    end
  end

endmodule
